ay_bus_ctrl: RTL and testbench

Bus-side controller for the AY-3-891x sound core. It decodes the BDIR/BC2/BC1 bus cycles coming from the CPU glue logic and latches the register address. It holds the 16×8 AY register file and drives the configuration fields consumed by the tone, noise, envelope and mixer datapaths, including the 5-bit noise period. It also generates the `ay_clk` enable strobe that paces those datapaths.

---
 rtl/ay_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_ay_bus_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ay_bus_ctrl.sv
// ay_bus_ctrl: AY-3-891x bus decode, 16x8 register file, field outputs and ay_clk prescaler.
// Define AY_BUS_SYNC_EN to pass bus and port inputs through 2-flop synchronizers.
module ay_bus_ctrl #(
    parameter logic [3:0] ADDR_HI = 4'h0,
    parameter int         CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bdir,
    input  logic        bc2,
    input  logic        bc1,
    input  logic [7:0]  da_in,
    output logic [7:0]  da_out,
    output logic        da_oe,
    output logic        ay_clk,
    output logic [11:0] tone_a,
    output logic [11:0] tone_b,
    output logic [11:0] tone_c,
    output logic [4:0]  noise_period,
    output logic [5:0]  mixer,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic [3:0]  env_shape,
    output logic        env_restart,
    output logic [7:0]  ioa_out,
    output logic [7:0]  iob_out,
    input  logic [7:0]  ioa_in,
    input  logic [7:0]  iob_in
);
    typedef enum logic [1:0] {IDLE, LATCH, READ, WRITE} state_t;

    logic [2:0] ctl;
    logic [7:0] da_s, ioa_s, iob_s;

`ifdef AY_BUS_SYNC_EN
    logic [2:0] ctl_s1_q, ctl_s2_q;
    logic [7:0] da_s1_q, da_s2_q, ioa_s1_q, ioa_s2_q, iob_s1_q, iob_s2_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_s1_q <= '0;
            ctl_s2_q <= '0;
            da_s1_q  <= '0;
            da_s2_q  <= '0;
            ioa_s1_q <= '0;
            ioa_s2_q <= '0;
            iob_s1_q <= '0;
            iob_s2_q <= '0;
        end else begin
            ctl_s1_q <= {bdir, bc2, bc1};
            ctl_s2_q <= ctl_s1_q;
            da_s1_q  <= da_in;
            da_s2_q  <= da_s1_q;
            ioa_s1_q <= ioa_in;
            ioa_s2_q <= ioa_s1_q;
            iob_s1_q <= iob_in;
            iob_s2_q <= iob_s1_q;
        end
    end
    assign ctl   = ctl_s2_q;
    assign da_s  = da_s2_q;
    assign ioa_s = ioa_s2_q;
    assign iob_s = iob_s2_q;
`else
    assign ctl   = {bdir, bc2, bc1};
    assign da_s  = da_in;
    assign ioa_s = ioa_in;
    assign iob_s = iob_in;
`endif

    state_t     state_q, state_d, mode;
    logic [3:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] da_out_q, da_out_d;
    logic       da_oe_q, da_oe_d;
    logic       env_restart_q, env_restart_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] regs_q [16];
    logic       wr_en;
    logic [7:0] rd_mask, rd_val;

    always_comb begin
        mode          = (ctl inside {3'b001, 3'b100, 3'b111}) ? LATCH :
                        (ctl == 3'b011) ? READ : (ctl == 3'b110) ? WRITE : IDLE;
        state_d       = mode;
        addr_d        = (mode == LATCH) ? da_s[3:0] : addr_q;
        sel_d         = (mode == LATCH) ? (da_s[7:4] == ADDR_HI) : sel_q;
        wdata_d       = (mode == WRITE) ? da_s : wdata_q;
        // Commit uses the pre-edge address, so WRITE straight into LATCH still lands correctly.
        wr_en         = (state_q == WRITE) && (mode != WRITE) && sel_q;
        env_restart_d = wr_en && (addr_q == 4'd13);
        rd_mask       = (addr_q inside {4'd1, 4'd3, 4'd5, 4'd13}) ? 8'h0F :
                        (addr_q inside {4'd6, 4'd8, 4'd9, 4'd10}) ? 8'h1F : 8'hFF;
        rd_val        = (addr_q == 4'd14) ? (regs_q[7][6] ? regs_q[14] : ioa_s) :
                        (addr_q == 4'd15) ? (regs_q[7][7] ? regs_q[15] : iob_s) :
                        regs_q[addr_q] & rd_mask;
        da_oe_d       = (state_q == READ) && sel_q;
        da_out_d      = da_oe_d ? rd_val : 8'h00;
        cnt_d         = (cnt_q == 8'd0) ? 8'(CLK_DIV - 1) : cnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            sel_q         <= 1'b0;
            wdata_q       <= '0;
            da_out_q      <= '0;
            da_oe_q       <= 1'b0;
            env_restart_q <= 1'b0;
            cnt_q         <= 8'(CLK_DIV - 1);
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            sel_q         <= sel_d;
            wdata_q       <= wdata_d;
            da_out_q      <= da_out_d;
            da_oe_q       <= da_oe_d;
            env_restart_q <= env_restart_d;
            cnt_q         <= cnt_d;
            if (wr_en) regs_q[addr_q] <= wdata_q;
        end
    end

    assign da_out       = da_out_q;
    assign da_oe        = da_oe_q;
    assign env_restart  = env_restart_q;
    assign ay_clk       = (cnt_q == 8'd0);
    assign tone_a       = {regs_q[1][3:0], regs_q[0]};
    assign tone_b       = {regs_q[3][3:0], regs_q[2]};
    assign tone_c       = {regs_q[5][3:0], regs_q[4]};
    assign noise_period = regs_q[6][4:0];
    assign mixer        = regs_q[7][5:0];
    assign amp_a        = regs_q[8][4:0];
    assign amp_b        = regs_q[9][4:0];
    assign amp_c        = regs_q[10][4:0];
    assign env_period   = {regs_q[12], regs_q[11]};
    assign env_shape    = regs_q[13][3:0];
    assign ioa_out      = regs_q[14];
    assign iob_out      = regs_q[15];
endmodule

// File: tb/tb_ay_bus_ctrl.sv
// tb_ay_bus_ctrl: vector-table and hand-written sequence bench for ay_bus_ctrl (default build).
module tb_ay_bus_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        bdir = 1'b0, bc2 = 1'b0, bc1 = 1'b0;
    logic [7:0]  da_in = '0, ioa_in = '0, iob_in = '0;
    logic [7:0]  da_out, ioa_out, iob_out;
    logic        da_oe, ay_clk, env_restart;
    logic [11:0] tone_a, tone_b, tone_c;
    logic [4:0]  noise_period, amp_a, amp_b, amp_c;
    logic [5:0]  mixer;
    logic [15:0] env_period;
    logic [3:0]  env_shape;

    localparam logic [2:0] M_IDLE = 3'b000, M_LAT = 3'b001, M_LAT4 = 3'b100, M_LAT7 = 3'b111;
    localparam logic [2:0] M_RD = 3'b011, M_WR = 3'b110;

    ay_bus_ctrl #(.ADDR_HI(4'h0), .CLK_DIV(8)) dut (
        .clk(clk), .reset_n(reset_n), .bdir(bdir), .bc2(bc2), .bc1(bc1),
        .da_in(da_in), .da_out(da_out), .da_oe(da_oe), .ay_clk(ay_clk),
        .tone_a(tone_a), .tone_b(tone_b), .tone_c(tone_c), .noise_period(noise_period),
        .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
        .env_period(env_period), .env_shape(env_shape), .env_restart(env_restart),
        .ioa_out(ioa_out), .iob_out(iob_out), .ioa_in(ioa_in), .iob_in(iob_in)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, pulses = 0;
    always @(posedge clk) #1 if (env_restart) pulses++;

    typedef struct {logic oe; logic [7:0] d;} rd_t;
    rd_t sb[$];

    typedef struct {logic [3:0] a; logic [7:0] w; logic [7:0] r;} vec_t;
    vec_t vec[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] m, input logic [7:0] d);
        {bdir, bc2, bc1} = m;
        da_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(M_LAT4, a);
        cyc(M_WR, d);
        cyc(M_IDLE, 8'h00);
    endtask

    task automatic rd(input string n, input logic [7:0] a, input logic oe, input logic [7:0] e);
        rd_t x;
        x.oe = oe;
        x.d  = e;
        sb.push_back(x);
        cyc(M_LAT, a);
        cyc(M_RD, 8'h00);
        chk({n, "_pre_oe"}, da_oe, 0);
        cyc(M_RD, 8'h00);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", n);
        end else begin
            x = sb.pop_front();
            chk({n, "_oe"}, da_oe, x.oe);
            chk({n, "_data"}, da_out, x.d);
        end
        cyc(M_IDLE, 8'h00);
        chk({n, "_hold_oe"}, da_oe, oe);
        cyc(M_IDLE, 8'h00);
        chk({n, "_drop_oe"}, da_oe, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0]  = '{4'd0,  8'hA5, 8'hA5};
        vec[1]  = '{4'd1,  8'hFF, 8'h0F};
        vec[2]  = '{4'd2,  8'h3C, 8'h3C};
        vec[3]  = '{4'd3,  8'hC3, 8'h03};
        vec[4]  = '{4'd4,  8'h5A, 8'h5A};
        vec[5]  = '{4'd5,  8'h96, 8'h06};
        vec[6]  = '{4'd6,  8'hFF, 8'h1F};
        vec[7]  = '{4'd7,  8'hFF, 8'hFF};
        vec[8]  = '{4'd8,  8'hF1, 8'h11};
        vec[9]  = '{4'd9,  8'hEE, 8'h0E};
        vec[10] = '{4'd10, 8'h3F, 8'h1F};
        vec[11] = '{4'd11, 8'h12, 8'h12};
        vec[12] = '{4'd12, 8'h34, 8'h34};
        vec[13] = '{4'd13, 8'hFB, 8'h0B};
        vec[14] = '{4'd14, 8'h77, 8'h77};
        vec[15] = '{4'd15, 8'h88, 8'h88};

        repeat (3) @(negedge clk);
        chk("rst_tone_a", tone_a, 0);
        chk("rst_env_period", env_period, 0);
        chk("rst_io", {ioa_out, iob_out, mixer, noise_period}, 0);
        chk("rst_rd", {da_oe, da_out, env_restart, ay_clk}, 0);
        reset_n = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            chk($sformatf("ay_clk_%0d", k), ay_clk, (k % 8 == 7));
            @(posedge clk);
            @(negedge clk);
        end
        chk("idle_oe", da_oe, 0);
        chk("idle_fields", {tone_b, tone_c, amp_a, amp_b, amp_c}, 0);

        wr(8'h06, 8'hFF);
        chk("noise_commit", noise_period, 5'h1F);
        rd("rd_r6", 8'h06, 1'b1, 8'h1F);

        pulses = 0;
        wr(8'h1D, 8'h0E);
        chk("desel_shape", env_shape, 0);
        chk("desel_pulses", pulses, 0);
        rd("rd_desel", 8'h1D, 1'b0, 8'h00);

        pulses = 0;
        cyc(M_LAT, 8'h0D);
        cyc(M_WR, 8'h0A);
        cyc(M_IDLE, 8'h00);
        chk("r13_pulse1", env_restart, 1);
        chk("r13_shape", env_shape, 4'hA);
        cyc(M_IDLE, 8'h00);
        chk("r13_pulse1_end", env_restart, 0);
        cyc(M_WR, 8'h0A);
        cyc(M_IDLE, 8'h00);
        chk("r13_pulse2", env_restart, 1);
        cyc(M_IDLE, 8'h00);
        chk("r13_pulses", pulses, 2);

        wr(8'h07, 8'h00);
        ioa_in = 8'h5A;
        iob_in = 8'hC3;
        wr(8'h0E, 8'h33);
        wr(8'h0F, 8'h66);
        chk("ioa_out", ioa_out, 8'h33);
        rd("rd_r14_pin", 8'h0E, 1'b1, 8'h5A);
        rd("rd_r15_pin", 8'h0F, 1'b1, 8'hC3);
        wr(8'h07, 8'h40);
        rd("rd_r14_reg", 8'h0E, 1'b1, 8'h33);

        cyc(M_LAT, 8'h00);
        cyc(M_WR, 8'h12);
        cyc(M_LAT4, 8'h01);
        chk("wr_to_latch", tone_a, 12'h012);
        cyc(M_RD, 8'h00);
        cyc(M_RD, 8'h00);
        chk("latch_new_addr", {da_oe, da_out}, 9'h100);
        cyc(M_IDLE, 8'h00);
        cyc(M_IDLE, 8'h00);
        cyc(M_LAT, 8'h02);
        cyc(M_WR, 8'h55);
        cyc(M_RD, 8'h00);
        chk("wr_to_read_field", tone_b, 12'h055);
        cyc(M_RD, 8'h00);
        chk("wr_to_read_data", {da_oe, da_out}, 9'h155);
        cyc(M_IDLE, 8'h00);
        cyc(M_IDLE, 8'h00);

        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(M_LAT7, {4'h0, vec[i].a});
            cyc(M_WR, vec[i].w);
            cyc(M_IDLE, 8'h00);
        end
        chk("tbl_pulses", pulses, 1);
        chk("tbl_tone_a", tone_a, 12'hFA5);
        chk("tbl_tone_b", tone_b, 12'h33C);
        chk("tbl_tone_c", tone_c, 12'h65A);
        chk("tbl_noise_mixer", {noise_period, mixer}, {5'h1F, 6'h3F});
        chk("tbl_amps", {amp_a, amp_b, amp_c}, {5'h11, 5'h0E, 5'h1F});
        chk("tbl_env", {env_period, env_shape}, {16'h3412, 4'hB});
        chk("tbl_io", {ioa_out, iob_out}, 16'h7788);
        for (int i = 0; i < 16; i++)
            rd($sformatf("tbl_rd_r%0d", i), {4'h0, vec[i].a}, 1'b1, vec[i].r);

        cyc(M_LAT, 8'h00);
        cyc(M_WR, 8'h99);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tone", {tone_a, tone_b, tone_c}, 0);
        chk("arst_misc", {noise_period, mixer, amp_a, amp_b, amp_c, env_shape}, 0);
        chk("arst_env_io", {env_period, ioa_out}, 0);
        chk("arst_rd", {da_oe, da_out, ay_clk, env_restart, iob_out}, 0);
        {bdir, bc2, bc1} = M_IDLE;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(M_IDLE, 8'h00);
        cyc(M_IDLE, 8'h00);
        chk("arst_no_commit", tone_a, 0);
        rd("rd_r0_after_rst", 8'h00, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
